// File: rtl/input_buf_ctrl.sv
// input_buf_ctrl: ping-pong address/enable controller for the per-row input
// memories of the systolic array. One bank is filled row by row while the
// other is drained with a diagonal skew (lane i lags lane 0 by i cycles).
//
// Handshake: wr_start and rd_start are single-cycle requests sampled on the
// rising edge. An accepted request starts its FSM; a rejected one changes
// no state and raises err for one cycle on the following cycle. wr_valid
// carries one row per cycle and is counted only while filling.
module input_buf_ctrl #(
  parameter int SYS_ROW = 16,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  input  logic              wr_valid,
  input  logic              rd_start,
  input  logic [CNT_W-1:0]  num_row,
  output logic [SYS_ROW-1:0] wr_en,
  output logic [ADDR_W-1:0] wr_addr [0:SYS_ROW-1],
  output logic              wr_bank,
  output logic [SYS_ROW-1:0] rd_en,
  output logic [ADDR_W-1:0] rd_addr [0:SYS_ROW-1],
  output logic              rd_bank,
  output logic              wr_done,
  output logic              rd_done,
  output logic              full,
  output logic              err,
  output logic [0:0]        wr_state,
  output logic [0:0]        rd_state
);

  // Time index wide enough for m + SYS_ROW - 2.
  localparam int T_W = CNT_W + $clog2(SYS_ROW) + 1;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_FILL  = 1'b1;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  // Bank bookkeeping
  logic [1:0]       valid;
  logic [1:0]       valid_nxt;
  logic [CNT_W-1:0] rows [0:1];
  logic             wr_ptr;
  logic             rd_ptr;

  // Write side
  logic [0:0]       w_state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] wr_n;
  logic             wr_last;   // last row issued, commit on next edge
  logic             wr_accept;
  logic             wr_reject;
  logic             wr_row;
  logic             wr_commit;
  logic [CNT_W-1:0] n_clamp;

  // Read side
  logic [0:0]       r_state;
  logic [T_W-1:0]   t;
  logic [T_W-1:0]   t_end;
  logic [T_W-1:0]   t_nxt;
  logic [CNT_W-1:0] rd_m;
  logic [CNT_W-1:0] m_nxt;
  logic             rd_accept;
  logic             rd_reject;
  logic             rd_finish;
  logic             rd_active_nxt;
  logic [SYS_ROW-1:0] lane_en_nxt;
  logic [ADDR_W-1:0]  lane_addr_nxt [0:SYS_ROW-1];

  assign wr_bank  = wr_ptr;
  assign rd_bank  = rd_ptr;
  assign wr_state = w_state;
  assign rd_state = r_state;

  // Write-side decisions, all based on registered valid flags
  always_comb begin
    n_clamp   = (num_row > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_row;
    wr_accept = (w_state == W_IDLE) && wr_start && !valid[wr_ptr] &&
                (num_row != '0);
    wr_reject = wr_start && !wr_accept;
    wr_row    = (w_state == W_FILL) && !wr_last && wr_valid;
    wr_commit = (w_state == W_FILL) && wr_last;
  end

  // Read-side decisions and the time index / row count for the next cycle
  always_comb begin
    rd_accept     = (r_state == R_IDLE) && rd_start && valid[rd_ptr];
    rd_reject     = rd_start && !rd_accept;
    rd_finish     = (r_state == R_DRAIN) && (t == t_end);
    rd_active_nxt = rd_accept || ((r_state == R_DRAIN) && !rd_finish);
    t_nxt         = '0;
    m_nxt         = rd_m;
    if (rd_accept) begin
      t_nxt = '0;
      m_nxt = rows[rd_ptr];
    end else if ((r_state == R_DRAIN) && !rd_finish) begin
      t_nxt = t + 1'b1;
    end
  end

  // Skewed lane enables/addresses for the upcoming cycle
  always_comb begin
    lane_en_nxt = '0;
    for (int i = 0; i < SYS_ROW; i++) begin
      lane_addr_nxt[i] = '0;
      if (rd_active_nxt && (t_nxt >= T_W'(i)) &&
          (t_nxt < T_W'(i) + T_W'(m_nxt))) begin
        lane_en_nxt[i]   = 1'b1;
        lane_addr_nxt[i] = ADDR_W'(t_nxt - T_W'(i));
      end
    end
  end

  // Next valid flags: write commit and drain finish always target
  // opposite banks, so set and clear never collide.
  always_comb begin
    valid_nxt = valid;
    if (wr_commit) valid_nxt[wr_ptr] = 1'b1;
    if (rd_finish) valid_nxt[rd_ptr] = 1'b0;
  end

  // Write FSM: count rows into the current write bank, then hand it over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      wr_cnt  <= '0;
      wr_n    <= '0;
      wr_last <= 1'b0;
      wr_ptr  <= 1'b0;
      wr_en   <= '0;
      wr_done <= 1'b0;
      for (int i = 0; i < SYS_ROW; i++) wr_addr[i] <= '0;
    end else begin
      wr_done <= wr_commit;
      wr_en   <= {SYS_ROW{wr_row}};
      for (int i = 0; i < SYS_ROW; i++)
        wr_addr[i] <= wr_row ? wr_cnt[ADDR_W-1:0] : '0;
      case (w_state)
        W_IDLE: begin
          if (wr_accept) begin
            w_state <= W_FILL;
            wr_cnt  <= '0;
            wr_n    <= n_clamp;
            wr_last <= 1'b0;
          end
        end
        W_FILL: begin
          if (wr_last) begin
            w_state <= W_IDLE;
            wr_last <= 1'b0;
            wr_cnt  <= '0;
            wr_ptr  <= ~wr_ptr;
          end else if (wr_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == wr_n - 1'b1) wr_last <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: walk t from 0 to m+SYS_ROW-2, driving the skewed lanes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      t       <= '0;
      t_end   <= '0;
      rd_m    <= '0;
      rd_ptr  <= 1'b0;
      rd_en   <= '0;
      rd_done <= 1'b0;
      for (int i = 0; i < SYS_ROW; i++) rd_addr[i] <= '0;
    end else begin
      rd_done <= rd_finish;
      rd_en   <= lane_en_nxt;
      for (int i = 0; i < SYS_ROW; i++) rd_addr[i] <= lane_addr_nxt[i];
      t       <= t_nxt;
      rd_m    <= m_nxt;
      case (r_state)
        R_IDLE: begin
          if (rd_accept) begin
            r_state <= R_DRAIN;
            t_end   <= T_W'(rows[rd_ptr]) + T_W'(SYS_ROW - 2);
          end
        end
        R_DRAIN: begin
          if (rd_finish) begin
            r_state <= R_IDLE;
            rd_ptr  <= ~rd_ptr;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Bank flags, stored row counts, full and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= '0;
      rows[0] <= '0;
      rows[1] <= '0;
      full    <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= valid_nxt;
      full  <= &valid_nxt;
      err   <= wr_reject || rd_reject;
      if (wr_commit) rows[wr_ptr] <= wr_n;
    end
  end

endmodule

// File: tb/tb_input_buf_ctrl.sv
// Testbench for input_buf_ctrl with SYS_ROW=4, DEPTH=8.
// Stimulus tasks push expected rows/pulses (tagged with the cycle they must
// appear in) into queues; a negedge monitor pops and compares.
module tb_input_buf_ctrl;

  localparam int SYS_ROW = 4;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int CNT_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              wr_start, wr_valid, rd_start;
  logic [CNT_W-1:0]  num_row;
  logic [SYS_ROW-1:0] wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr [0:SYS_ROW-1];
  logic [ADDR_W-1:0] rd_addr [0:SYS_ROW-1];
  logic              wr_bank, rd_bank, wr_done, rd_done, full, err;
  logic [0:0]        wr_state, rd_state;

  input_buf_ctrl #(.SYS_ROW(SYS_ROW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_valid(wr_valid),
    .rd_start(rd_start), .num_row(num_row), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_bank(wr_bank), .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .wr_done(wr_done), .rd_done(rd_done), .full(full), .err(err),
    .wr_state(wr_state), .rd_state(rd_state)
  );

  // ---------------- scoreboard ----------------
  // write entry: {cycle, bank, addr}; read entry: {cycle, lane, bank, addr}
  logic [19:0] exp_wr_q[$];
  logic [21:0] exp_rd_q[$];
  logic [15:0] exp_wd_q[$];
  logic [15:0] exp_rdd_q[$];
  logic [15:0] exp_err_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_pulse(input string name, input logic sig,
                           inout logic [15:0] q[$]);
    if (sig) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
      end else begin
        if (q[0] != 16'(cyc)) begin
          errors++;
          $display("FAIL %s: pulse at cycle %0d expected cycle %0d", name, cyc, q[0]);
        end
        void'(q.pop_front());
      end
    end
  endtask

  // Monitor: compare every presented row and pulse against the queues
  always @(negedge clk) begin
    logic [19:0] wgot, wexp;
    logic [21:0] rgot, rexp;
    if (wr_en != '0) begin
      checks++;
      wgot = {16'(cyc), wr_bank, wr_addr[0]};
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_row: unexpected write got %h", wgot);
      end else begin
        wexp = exp_wr_q.pop_front();
        if (wgot != wexp || wr_en != '1 || wr_addr[1] != wr_addr[0] ||
            wr_addr[2] != wr_addr[0] || wr_addr[3] != wr_addr[0]) begin
          errors++;
          $display("FAIL wr_row: got %h en %b expected %h en 1111", wgot, wr_en, wexp);
        end
      end
    end
    for (int i = 0; i < SYS_ROW; i++) begin
      if (rd_en[i]) begin
        checks++;
        rgot = {16'(cyc), 2'(i), rd_bank, rd_addr[i]};
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_row: unexpected read got %h", rgot);
        end else begin
          rexp = exp_rd_q.pop_front();
          if (rgot != rexp) begin
            errors++;
            $display("FAIL rd_row: got %h expected %h", rgot, rexp);
          end
        end
      end else if (rd_addr[i] != '0) begin
        checks++;
        errors++;
        $display("FAIL rd_addr_idle: lane %0d got %0d expected 0", i, rd_addr[i]);
      end
    end
    chk_pulse("wr_done", wr_done, exp_wd_q);
    chk_pulse("rd_done", rd_done, exp_rdd_q);
    chk_pulse("err", err, exp_err_q);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill the write bank; pat bit k is wr_valid in the k-th cycle after start.
  task automatic fill(input int num, input logic bank, input logic [31:0] pat);
    int eff, cnt, k;
    eff = (num > DEPTH) ? DEPTH : num;
    num_row  = CNT_W'(num);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    cnt = 0;
    k   = 0;
    while (cnt < eff && k < 64) begin
      wr_valid = pat[k % 32];
      if (wr_valid) begin
        exp_wr_q.push_back({16'(cyc + 1), bank, 3'(cnt)});
        cnt++;
        if (cnt == eff) exp_wd_q.push_back(16'(cyc + 2));
      end
      k++;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // Drain m rows of the read bank; lane i reads row r in cycle c+1+i+r.
  task automatic drain(input int m, input logic bank);
    int c;
    c = cyc;
    for (int tt = 0; tt < m + SYS_ROW - 1; tt++)
      for (int i = 0; i < SYS_ROW; i++)
        if (tt >= i && tt < i + m)
          exp_rd_q.push_back({16'(c + 1 + tt), 2'(i), bank, 3'(tt - i)});
    exp_rdd_q.push_back(16'(c + m + SYS_ROW));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (m + SYS_ROW - 1) tick();
  endtask

  task automatic bad_wr(input int num);
    exp_err_q.push_back(16'(cyc + 1));
    num_row  = CNT_W'(num);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tick();
  endtask

  task automatic bad_rd();
    exp_err_q.push_back(16'(cyc + 1));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    rst = 1'b1; wr_start = 1'b0; wr_valid = 1'b0; rd_start = 1'b0; num_row = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_flags", int'({wr_bank, rd_bank, wr_done, rd_done, full, err}), 0);
    for (int i = 0; i < SYS_ROW; i++) begin
      chk("rst_wr_addr", int'(wr_addr[i]), 0);
      chk("rst_rd_addr", int'(rd_addr[i]), 0);
    end
    chk("rst_states", int'({wr_state, rd_state}), 0);
    tick();
    rst = 1'b0;
    tick();

    // read of an empty bank after reset
    bad_rd();

    // 3-row tile into bank 0, then skewed drain
    fill(3, 1'b0, 32'hFFFF_FFFF);
    tick(); tick();
    chk("full_one_bank", int'(full), 0);
    drain(3, 1'b0);
    tick();

    // 5 rows with gaps into bank 1
    fill(5, 1'b1, 32'b1101101);
    tick(); tick();

    // bank 0 again -> both banks full, third start rejected
    fill(3, 1'b0, 32'hFFFF_FFFF);
    tick(); tick();
    chk("full_both", int'(full), 1);
    bad_wr(2);
    chk("full_after_reject", int'(full), 1);

    // drain bank 1 (5 rows)
    drain(5, 1'b1);
    tick();
    chk("full_after_drain", int'(full), 0);

    // concurrent: drain bank 0 while filling bank 1 with clamped 12 rows
    fork
      drain(3, 1'b0);
      fill(12, 1'b1, 32'hFFFF_FFFF);
    join
    tick(); tick();
    drain(8, 1'b1);
    tick();

    // zero-row start rejected
    bad_wr(0);

    // reset in the middle of a drain (t=2)
    fill(2, 1'b0, 32'hFFFF_FFFF);
    tick(); tick();
    c = cyc;
    exp_rd_q.push_back({16'(c + 1), 2'd0, 1'b0, 3'd0});
    exp_rd_q.push_back({16'(c + 2), 2'd0, 1'b0, 3'd1});
    exp_rd_q.push_back({16'(c + 2), 2'd1, 1'b0, 3'd0});
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", int'(rd_en), 0);
    chk("midrst_rd_done", int'(rd_done), 0);
    chk("midrst_full", int'(full), 0);
    tick();
    rst = 1'b0;
    tick();
    bad_rd();
    repeat (3) tick();

    chk("left_wr_rows", exp_wr_q.size(), 0);
    chk("left_rd_rows", exp_rd_q.size(), 0);
    chk("left_wr_done", exp_wd_q.size(), 0);
    chk("left_rd_done", exp_rdd_q.size(), 0);
    chk("left_err", exp_err_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
